// File: rtl/alu_div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Works on operand magnitudes and produces one quotient bit per cycle. Signs are fixed up at the end.
module alu_div_seq #(
  parameter int LEN_DATA = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LEN_DATA-1:0] dividend,
  input  logic [LEN_DATA-1:0] divisor,
  input  logic                is_signed,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [LEN_DATA-1:0] quotient,
  output logic [LEN_DATA-1:0] remainder,
  output logic                div_by_zero
);

  localparam int W  = LEN_DATA;
  localparam int CW = $clog2(LEN_DATA);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  rem_q, shf_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          neg_quo_q, neg_rem_q;

  logic          dividend_neg, divisor_neg;
  logic [W-1:0]  dividend_mag, divisor_mag;
  logic [W:0]    trial;
  logic          trial_ok;
  logic [W-1:0]  rem_shift;

  assign in_ready  = (state == IDLE);
  assign res_valid = (state == DONE);

  assign dividend_neg = is_signed & dividend[W-1];
  assign divisor_neg  = is_signed & divisor[W-1];
  assign dividend_mag = dividend_neg ? -dividend : dividend;
  assign divisor_mag  = divisor_neg  ? -divisor  : divisor;

  // Partial remainder stays below the divisor, so a set bit W after the subtract means a borrow
  assign trial     = {rem_q, shf_q[W-1]} - {1'b0, dvs_q};
  assign trial_ok  = ~trial[W];
  assign rem_shift = {rem_q[W-2:0], shf_q[W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:     if (cnt_q == '0) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q       <= '0;
      shf_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            neg_quo_q <= dividend_neg ^ divisor_neg;
            neg_rem_q <= dividend_neg;
            // Divide by zero bypasses the iteration and returns the raw dividend
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              rem_q <= '0;
              shf_q <= dividend_mag;
              dvs_q <= divisor_mag;
              cnt_q <= CW'(LEN_DATA - 1);
            end
          end
        end
        RUN: begin
          rem_q <= trial_ok ? trial[W-1:0] : rem_shift;
          shf_q <= {shf_q[W-2:0], trial_ok};
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        FIXUP: begin
          quotient    <= neg_quo_q ? -shf_q : shf_q;
          remainder   <= neg_rem_q ? -rem_q : rem_q;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq: directed cases plus randomized operands.
// Results are compared against an arithmetic reference model.
module tb_alu_div_seq;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         is_signed;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t exp_q[$];

  alu_div_seq #(.LEN_DATA(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: language division truncates toward zero, and the remainder takes the dividend's sign
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   e;
    longint sa, sb;
    e.dbz = 1'b0;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else if (s) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Whenever a result is presented it must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected res_valid", 32'(res_valid), 32'd0);
      end else begin
        checkOutput("quotient", quotient, exp_q[0].q);
        checkOutput("remainder", remainder, exp_q[0].r);
        checkOutput("div_by_zero", 32'(div_by_zero), 32'(exp_q[0].dbz));
        checkOutput("in_ready while busy", 32'(in_ready), 32'd0);
        if (res_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Entered and left #1 after a rising edge
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s, input int hold);
    int guard;
    int lat;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("in_ready before accept", 32'(in_ready), 32'd1);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(a, b, s));
    #1;
    in_valid  = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (res_valid === 1'b1) break;
    end
    checkOutput("latency", 32'(lat), (b == '0) ? 32'd1 : 32'(W + 2));
    repeat (hold + 1) @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    checkOutput("res_valid after handoff", 32'(res_valid), 32'd0);
    checkOutput("in_ready after handoff", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t          e;
    logic [W-1:0]  a, b;
    logic          s;
    int            sel;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    #12;
    checkOutput("reset res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset quotient", quotient, 32'd0);
    checkOutput("reset remainder", remainder, 32'd0);
    checkOutput("reset div_by_zero", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("in_ready after reset", 32'(in_ready), 32'd1);

    // Hand-computed values that pin the model itself
    e = model(32'd100, 32'd7, 1'b0);
    checkOutput("model 100/7 q", e.q, 32'd14);
    checkOutput("model 100/7 r", e.r, 32'd2);
    e = model(32'hFFFFFFF9, 32'd2, 1'b1);
    checkOutput("model -7/2 q", e.q, 32'hFFFFFFFD);
    checkOutput("model -7/2 r", e.r, 32'hFFFFFFFF);
    e = model(32'd7, 32'hFFFFFFFE, 1'b1);
    checkOutput("model 7/-2 q", e.q, 32'hFFFFFFFD);
    checkOutput("model 7/-2 r", e.r, 32'd1);
    e = model(32'h80000000, 32'hFFFFFFFF, 1'b1);
    checkOutput("model MIN/-1 q", e.q, 32'h80000000);
    checkOutput("model MIN/-1 r", e.r, 32'd0);
    e = model(32'd5, 32'd0, 1'b1);
    checkOutput("model 5/0 q", e.q, 32'hFFFFFFFF);
    checkOutput("model 5/0 r", e.r, 32'd5);

    $display("[TB] directed cases");
    applyStimulus(32'd100, 32'd7, 1'b0, 0);
    applyStimulus(32'hFFFFFFF9, 32'd2, 1'b1, 0);
    applyStimulus(32'd7, 32'hFFFFFFFE, 1'b1, 1);
    applyStimulus(32'd5, 32'd0, 1'b0, 0);
    applyStimulus(32'd5, 32'd0, 1'b1, 2);
    applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1, 0);
    applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
    applyStimulus(32'hFFFFFFFF, 32'd1, 1'b0, 0);
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 0);

    $display("[TB] backpressure");
    applyStimulus(32'd1000, 32'd33, 1'b0, 4);

    $display("[TB] random operands");
    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      b   = $urandom;
      s   = 1'($urandom);
      sel = $urandom_range(0, 6);
      case (sel)
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = '1;
        3: a = 32'h80000000;
        4: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      applyStimulus(a, b, s, $urandom_range(0, 3));
    end

    $display("[TB] reset during RUN");
    dividend  = 32'd12345;
    divisor   = 32'd17;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("mid-run reset res_valid", 32'(res_valid), 32'd0);
    checkOutput("mid-run reset quotient", quotient, 32'd0);
    checkOutput("mid-run reset remainder", remainder, 32'd0);
    checkOutput("mid-run reset in_ready", 32'(in_ready), 32'd1);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("in_ready after release", 32'(in_ready), 32'd1);
    applyStimulus(32'd100, 32'd7, 1'b0, 0);
    checkOutput("final quotient", quotient, 32'd14);
    checkOutput("final remainder", remainder, 32'd2);
    checkOutput("no pending results", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
